// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall/bubble and redirect flush.
// Latency: stall/bubble/flush/forward selects are combinational from ID inputs and tracker state.
// Backpressure: stall_o holds PC and IF/ID for one cycle per load-use pair; a redirect overrides the stall.
module hazard_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_regfile_we_i,
    input  logic        id_detect_r1_i,
    input  logic        id_detect_r2_i,
    input  logic        id_is_load_i,
    input  logic        ex_redirect_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic        flush_o,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
    output logic [15:0] stall_cnt_o
);

    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_we, mem_we, wb_we;
    logic        ex_ld, mem_ld;
    logic [15:0] stall_cnt_q;

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic load_use;

    // MEM load flag mirrors the in-flight instruction but no current rule consumes it.
    logic unused_mem_ld;
    assign unused_mem_ld = mem_ld;

    always_comb begin
        ex_a  = ex_we  && (ex_rd  != 5'd0) && (ex_rd  == id_rs1_i) && id_valid_i && id_detect_r1_i;
        ex_b  = ex_we  && (ex_rd  != 5'd0) && (ex_rd  == id_rs2_i) && id_valid_i && id_detect_r2_i;
        mem_a = mem_we && (mem_rd != 5'd0) && (mem_rd == id_rs1_i) && id_valid_i && id_detect_r1_i;
        mem_b = mem_we && (mem_rd != 5'd0) && (mem_rd == id_rs2_i) && id_valid_i && id_detect_r2_i;
        wb_a  = wb_we  && (wb_rd  != 5'd0) && (wb_rd  == id_rs1_i) && id_valid_i && id_detect_r1_i;
        wb_b  = wb_we  && (wb_rd  != 5'd0) && (wb_rd  == id_rs2_i) && id_valid_i && id_detect_r2_i;
        load_use = ex_ld && (ex_a || ex_b);
    end

    // An EX load cannot forward yet; its match is the load-use case and is skipped.
    always_comb begin
        fwd_a_sel_o = 2'b00;
        if (ex_a && !load_use) fwd_a_sel_o = 2'b01;
        else if (mem_a)        fwd_a_sel_o = 2'b10;
        else if (wb_a)         fwd_a_sel_o = 2'b11;

        fwd_b_sel_o = 2'b00;
        if (ex_b && !load_use) fwd_b_sel_o = 2'b01;
        else if (mem_b)        fwd_b_sel_o = 2'b10;
        else if (wb_b)         fwd_b_sel_o = 2'b11;
    end

    assign stall_o     = load_use && !ex_redirect_i;
    assign bubble_o    = stall_o;
    assign flush_o     = ex_redirect_i && rst_n_i;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_rd       <= 5'd0;
            ex_we       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_rd      <= 5'd0;
            mem_we      <= 1'b0;
            mem_ld      <= 1'b0;
            wb_rd       <= 5'd0;
            wb_we       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            wb_rd  <= mem_rd;
            wb_we  <= mem_we;
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            mem_ld <= ex_ld;
            if (bubble_o || flush_o) begin
                ex_rd <= 5'd0;
                ex_we <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_rd <= id_rd_i;
                ex_we <= id_regfile_we_i && id_valid_i;
                ex_ld <= id_is_load_i && id_valid_i;
            end
            if (stall_o && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against an in-flight list model.
module tb_hazard_unit;

    logic        clk, rst_n;
    logic        id_valid, id_we, id_det1, id_det2, id_ld, ex_redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall, bubble, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    // index 0 = youngest in flight (EX), 1 = MEM, 2 = WB
    instr_t      flight[3];
    logic [15:0] m_cnt;

    hazard_unit dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_regfile_we_i(id_we),
        .id_detect_r1_i (id_det1),
        .id_detect_r2_i (id_det2),
        .id_is_load_i   (id_ld),
        .ex_redirect_i  (ex_redirect),
        .stall_o        (stall),
        .bubble_o       (bubble),
        .flush_o        (flush),
        .fwd_a_sel_o    (fwd_a),
        .fwd_b_sel_o    (fwd_b),
        .stall_cnt_o    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hits(input instr_t e, input logic [4:0] rs, input logic det);
        return e.we && (e.rd != 5'd0) && (e.rd == rs) && id_valid && det;
    endfunction

    task automatic model_eval(output logic lu, output logic [1:0] fa, output logic [1:0] fb);
        lu = flight[0].ld && (hits(flight[0], id_rs1, id_det1) || hits(flight[0], id_rs2, id_det2));
        fa = 2'b00;
        fb = 2'b00;
        // scan oldest to youngest so the youngest producer wins; code = age + 1
        for (int s = 2; s >= 0; s--) begin
            if (hits(flight[s], id_rs1, id_det1) && !(s == 0 && lu)) fa = 2'(s + 1);
            if (hits(flight[s], id_rs2, id_det2) && !(s == 0 && lu)) fb = 2'(s + 1);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) flight[s] = '{5'd0, 1'b0, 1'b0};
        m_cnt = 16'd0;
    endtask

    task automatic check_all();
        logic lu;
        logic [1:0] fa, fb;
        model_eval(lu, fa, fb);
        check("stall",  stall,     lu && !ex_redirect);
        check("bubble", bubble,    lu && !ex_redirect);
        check("flush",  flush,     ex_redirect && rst_n);
        check("fwd_a",  fwd_a,     fa);
        check("fwd_b",  fwd_b,     fb);
        check("cnt",    stall_cnt, m_cnt);
    endtask

    task automatic model_clock();
        logic lu, st;
        logic [1:0] fa, fb;
        model_eval(lu, fa, fb);
        st = lu && !ex_redirect;
        flight[2] = flight[1];
        flight[1] = flight[0];
        if (st || ex_redirect) flight[0] = '{5'd0, 1'b0, 1'b0};
        else flight[0] = '{id_rd, id_we && id_valid, id_ld && id_valid};
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic idrv(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                        input logic [4:0] rs1, input logic d1, input logic [4:0] rs2, input logic d2,
                        input logic redir);
        id_valid = v; id_rd = rd; id_we = we; id_ld = ld;
        id_rs1 = rs1; id_det1 = d1; id_rs2 = rs2; id_det2 = d2;
        ex_redirect = redir;
    endtask

    // called just after a falling edge; returns at the next falling edge
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idrv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU writes: EX, then MEM, then WB forwarding
        idrv(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
        idrv(1, 6, 1, 0, 5, 1, 5, 1, 0); #1;
        check("b2b_fa", fwd_a, 2'b01); check("b2b_fb", fwd_b, 2'b01); check("b2b_st", stall, 0);
        step();
        idrv(1, 0, 0, 0, 5, 1, 0, 0, 0); #1; check("mem_fa", fwd_a, 2'b10); step();
        idrv(1, 0, 0, 0, 5, 1, 0, 0, 0); #1; check("wb_fa", fwd_a, 2'b11); step();

        // load-use: one stall, then MEM forwarding of load data
        idrv(1, 7, 1, 1, 0, 0, 0, 0, 0); step();
        idrv(1, 12, 1, 0, 0, 0, 7, 1, 0); #1;
        check("lu_st", stall, 1); check("lu_bub", bubble, 1); check("lu_cnt0", stall_cnt, 16'd0);
        step();
        check("lu_cnt1", stall_cnt, 16'd1);
        #1; check("lu_fb", fwd_b, 2'b10); check("lu_st2", stall, 0);
        step();

        // x0 never forwards; undetected operand never forwards nor stalls
        idrv(1, 0, 1, 0, 0, 0, 0, 0, 0); step();
        idrv(1, 0, 0, 0, 0, 1, 0, 0, 0); #1; check("x0_fa", fwd_a, 2'b00); step();
        idrv(1, 3, 1, 1, 0, 0, 0, 0, 0); step();
        idrv(1, 0, 0, 0, 0, 0, 3, 0, 0); #1;
        check("det_fb", fwd_b, 2'b00); check("det_st", stall, 0);
        step();

        // redirect while load-use holds
        idrv(1, 8, 1, 1, 0, 0, 0, 0, 0); step();
        idrv(1, 10, 1, 1, 8, 1, 0, 0, 1); #1;
        check("rd_fl", flush, 1); check("rd_st", stall, 0); check("rd_bub", bubble, 0);
        step();
        check("rd_cnt", stall_cnt, 16'd1);
        idrv(1, 0, 0, 0, 10, 1, 8, 1, 0); #1;
        check("rd_ex_fa", fwd_a, 2'b00); check("rd_ex_st", stall, 0); check("rd_fb", fwd_b, 2'b10);
        step();

        // priority: youngest producer wins
        repeat (3) begin idrv(1, 9, 1, 0, 0, 0, 0, 0, 0); step(); end
        idrv(1, 0, 0, 0, 9, 1, 9, 1, 0); #1;
        check("pri_fa", fwd_a, 2'b01); check("pri_fb", fwd_b, 2'b01);
        step();

        // counter saturation from a preloaded value
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 16'hFFFD;
        repeat (3) begin
            idrv(1, 7, 1, 1, 0, 0, 0, 0, 0); step();
            idrv(1, 0, 0, 0, 7, 1, 0, 0, 0); step();
        end
        check("sat_cnt", stall_cnt, 16'hFFFF);

        // asynchronous reset in the middle of a stall
        idrv(1, 7, 1, 1, 0, 0, 0, 0, 0); step();
        idrv(1, 0, 0, 0, 7, 1, 0, 0, 0); #1;
        check("ar_pre_st", stall, 1);
        rst_n = 1'b0;
        #1;
        check("ar_st", stall, 0); check("ar_bub", bubble, 0); check("ar_cnt", stall_cnt, 16'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idrv(1, 7, 1, 1, 0, 0, 0, 0, 0); step();
        idrv(1, 0, 0, 0, 7, 1, 0, 0, 0); #1;
        check("post_rst_st", stall, 1);
        step();

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
            idrv(($urandom % 8) != 0, 5'($urandom_range(0, 4)), 1'($urandom), ($urandom % 3) == 0,
                 5'($urandom_range(0, 4)), 1'($urandom), 5'($urandom_range(0, 4)), 1'($urandom),
                 ($urandom % 10) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
